// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory fetch bus: request/address out of the fetch unit,
// read data and one-cycle completion strobe back from memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// PC / instruction-fetch sequencer: FETCH a word over the imem bus, hold it
// for decode during EXEC, then commit the next PC selected by pc_control.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall,
  instr_fetch_unit_if.master         imem,
  output logic [31:0]                instruction,
  output logic                       instr_valid,
  input  logic [3:0]                 pc_control,
  input  logic                       alu_zero,
  input  logic [31:0]                rs_data,
  output logic [31:0]                pc,
  output logic [31:0]                pc_plus4,
  output logic [31:0]                retired_count
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_EXEC  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instruction_q, instruction_d;
  logic [31:0] retired_count_q, retired_count_d;

  logic [31:0] next_pc;
  logic [31:0] jump_target;
  logic [31:0] jr_target;
  logic [31:0] branch_target;
  logic        branch_take;

  assign pc_plus4      = pc_q + 32'd4;
  assign jump_target   = {pc_plus4[31:28], instruction_q[25:0], 2'b00};
  assign jr_target     = rs_data & 32'hFFFF_FFFC;
  assign branch_target = pc_plus4 + {{14{instruction_q[15]}}, instruction_q[15:0], 2'b00};
  // Bit 26 distinguishes bne from beq, so it simply inverts the zero test.
  assign branch_take   = alu_zero ^ instruction_q[26];

  always_comb begin
    next_pc = pc_plus4;
    case (pc_control)
      4'b0001: next_pc = jump_target;
      4'b0010: next_pc = jr_target;
      4'b0011: next_pc = branch_take ? branch_target : pc_plus4;
      default: next_pc = pc_plus4;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    instruction_d   = instruction_q;
    retired_count_d = retired_count_q;
    case (state_q)
      S_FETCH: begin
        if (imem.imem_ack) begin
          instruction_d = imem.imem_rdata;
          state_d       = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!stall) begin
          pc_d            = next_pc;
          retired_count_d = retired_count_q + 32'd1;
          state_d         = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      instruction_q   <= 32'h0;
      retired_count_q <= 32'h0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      instruction_q   <= instruction_d;
      retired_count_q <= retired_count_d;
    end
  end

  // Request is masked by rst so nothing is issued while reset is held.
  assign imem.imem_req  = (state_q == S_FETCH) && !rst;
  assign imem.imem_addr = pc_q;
  assign instr_valid    = (state_q == S_EXEC);
  assign instruction    = instruction_q;
  assign pc             = pc_q;
  assign retired_count  = retired_count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: sequential fetch, jumps, branches,
// handshake delay, stall, and reset during an outstanding fetch.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst;
  logic        stall;
  logic [31:0] instruction;
  logic        instr_valid;
  logic [3:0]  pc_control;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] retired_count;

  int checks;
  int errors;
  logic [31:0] exp_retired;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .imem          (bus.master),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .pc_control    (pc_control),
    .alu_zero      (alu_zero),
    .rs_data       (rs_data),
    .pc            (pc),
    .pc_plus4      (pc_plus4),
    .retired_count (retired_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all driving happens just after a falling edge.
  task automatic fetch_word(input logic [31:0] word);
    bus.imem_rdata = word;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'hDEAD_BEEF;
    #1;
  endtask

  task automatic exec_commit(input logic [3:0] code, input logic zero, input logic [31:0] rs);
    pc_control = code;
    alu_zero   = zero;
    rs_data    = rs;
    @(negedge clk);
    pc_control  = 4'b0000;
    alu_zero    = 1'b0;
    rs_data     = 32'h0;
    exp_retired = exp_retired + 32'd1;
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.imem_req !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_req: got %b expected 0", bus.imem_req);
    end
    checks++;
    if (pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_pc: got %h expected 00000000", pc);
    end
    checks++;
    if (instruction !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_instruction: got %h expected 00000000", instruction);
    end
    checks++;
    if (instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_valid: got %b expected 0", instr_valid);
    end
    checks++;
    if (retired_count !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_count: got %h expected 00000000", retired_count);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_retired = 32'h0;
    #1;
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL first_req: got req=%b addr=%h expected req=1 addr=00000000",
               bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_sequential;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4 * i)) begin
        errors++;
        $display("[TB] FAIL seq_addr[%0d]: got req=%b addr=%h expected req=1 addr=%h",
                 i, bus.imem_req, bus.imem_addr, 32'(4 * i));
      end
      fetch_word(32'h0000_1000 + 32'(i));
      checks++;
      if (instr_valid !== 1'b1 || bus.imem_req !== 1'b0 ||
          instruction !== 32'h0000_1000 + 32'(i)) begin
        errors++;
        $display("[TB] FAIL seq_exec[%0d]: got valid=%b req=%b instr=%h expected valid=1 req=0 instr=%h",
                 i, instr_valid, bus.imem_req, instruction, 32'h0000_1000 + 32'(i));
      end
      exec_commit(4'b0000, 1'b0, 32'h0);
      if (i == 2) begin
        checks++;
        if (retired_count !== 32'd3) begin
          errors++;
          $display("[TB] FAIL seq_count3: got %0d expected 3", retired_count);
        end
      end
    end
  endtask

  task automatic test_jumps;
    // jr drops the low two bits of rs_data.
    fetch_word(32'h0000_0008);
    exec_commit(4'b0010, 1'b0, 32'h0000_2003);
    checks++;
    if (pc !== 32'h0000_2000) begin
      errors++;
      $display("[TB] FAIL jr_target: got %h expected 00002000", pc);
    end
    fetch_word(32'h0000_0008);
    exec_commit(4'b0010, 1'b0, 32'h1000_0040);
    checks++;
    if (pc !== 32'h1000_0040) begin
      errors++;
      $display("[TB] FAIL jr_setup: got %h expected 10000040", pc);
    end
    fetch_word(32'h0800_0100);
    exec_commit(4'b0001, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h1000_0400) begin
      errors++;
      $display("[TB] FAIL j_target: got %h expected 10000400", pc);
    end
    fetch_word(32'h0000_0000);
    exec_commit(4'b1111, 1'b1, 32'h5555_5555);
    checks++;
    if (pc !== 32'h1000_0404) begin
      errors++;
      $display("[TB] FAIL other_code: got %h expected 10000404", pc);
    end
  endtask

  task automatic test_branches;
    logic [31:0] words [3];
    logic        zeros [3];
    logic [31:0] targets [3];
    words[0] = 32'h1000_FFFE; zeros[0] = 1'b1; targets[0] = 32'h0000_00FC;
    words[1] = 32'h1000_FFFE; zeros[1] = 1'b0; targets[1] = 32'h0000_0104;
    words[2] = 32'h1400_FFFE; zeros[2] = 1'b0; targets[2] = 32'h0000_00FC;
    for (int i = 0; i < 3; i++) begin
      fetch_word(32'h0);
      exec_commit(4'b0010, 1'b0, 32'h0000_0100);
      fetch_word(words[i]);
      exec_commit(4'b0011, zeros[i], 32'h0);
      checks++;
      if (pc !== targets[i]) begin
        errors++;
        $display("[TB] FAIL branch[%0d]: got %h expected %h", i, pc, targets[i]);
      end
    end
  endtask

  task automatic test_wrap;
    fetch_word(32'h0);
    exec_commit(4'b0010, 1'b0, 32'hFFFF_FFFF);
    fetch_word(32'h0);
    exec_commit(4'b0000, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h0000_0000) begin
      errors++;
      $display("[TB] FAIL pc_wrap: got %h expected 00000000", pc);
    end
  endtask

  task automatic test_handshake_stall;
    logic [31:0] held_pc;
    held_pc = pc;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== held_pc || instr_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL ack_wait[%0d]: got req=%b addr=%h valid=%b expected req=1 addr=%h valid=0",
                 k, bus.imem_req, bus.imem_addr, instr_valid, held_pc);
      end
      if (k < 3) begin
        @(negedge clk);
        #1;
      end
    end
    fetch_word(32'hABCD_0123);
    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (k == 2) begin
        bus.imem_rdata = 32'h7777_7777;
        bus.imem_ack   = 1'b1;
      end
      @(negedge clk);
      bus.imem_ack = 1'b0;
      #1;
      checks++;
      if (instr_valid !== 1'b1 || pc !== held_pc ||
          instruction !== 32'hABCD_0123 || retired_count !== exp_retired) begin
        errors++;
        $display("[TB] FAIL stall[%0d]: got valid=%b pc=%h instr=%h count=%h expected valid=1 pc=%h instr=abcd0123 count=%h",
                 k, instr_valid, pc, instruction, retired_count, held_pc, exp_retired);
      end
    end
    stall = 1'b0;
    exec_commit(4'b0000, 1'b0, 32'h0);
    checks++;
    if (pc !== held_pc + 32'd4 || retired_count !== exp_retired) begin
      errors++;
      $display("[TB] FAIL stall_release: got pc=%h count=%h expected pc=%h count=%h",
               pc, retired_count, held_pc + 32'd4, exp_retired);
    end
  endtask

  task automatic test_reset_mid_fetch;
    checks++;
    if (bus.imem_req !== 1'b1 || pc === 32'h0) begin
      errors++;
      $display("[TB] FAIL pre_reset: got req=%b pc=%h expected req=1 and nonzero pc",
               bus.imem_req, pc);
    end
    rst = 1'b1;
    @(negedge clk);
    bus.imem_rdata = 32'h1234_5678;
    bus.imem_ack   = 1'b1;
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    rst            = 1'b0;
    exp_retired    = 32'h0;
    #1;
    checks++;
    if (pc !== 32'h0 || retired_count !== 32'h0 || instruction !== 32'h0 || instr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_drop: got pc=%h count=%h instr=%h valid=%b expected 0/0/0/0",
               pc, retired_count, instruction, instr_valid);
    end
    checks++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL refetch: got req=%b addr=%h expected req=1 addr=00000000",
               bus.imem_req, bus.imem_addr);
    end
    fetch_word(32'h0000_00AA);
    exec_commit(4'b0000, 1'b0, 32'h0);
    checks++;
    if (pc !== 32'h4 || retired_count !== 32'd1) begin
      errors++;
      $display("[TB] FAIL post_reset_run: got pc=%h count=%h expected 00000004 / 1",
               pc, retired_count);
    end
  endtask

  initial begin
    checks         = 0;
    errors         = 0;
    exp_retired    = 32'h0;
    rst            = 1'b1;
    stall          = 1'b0;
    pc_control     = 4'b0000;
    alu_zero       = 1'b0;
    rs_data        = 32'h0;
    bus.imem_rdata = 32'h0;
    bus.imem_ack   = 1'b0;
    @(negedge clk);
    test_reset;
    test_sequential;
    test_jumps;
    test_branches;
    test_wrap;
    test_handshake_stall;
    test_reset_mid_fetch;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
